// File: rtl/speed_round_ctrl_pkg.sv
// Shared game package: FSM state encoding and round result codes.
// Reused by the game FSM, the display mux and the speed round sequencer.
package speed_round_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_ROUND,
    S_SETTLE,
    S_DECIDE,
    S_EXIT
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE  = 2'b00,
    RES_LEFT  = 2'b01,
    RES_RIGHT = 2'b10,
    RES_TIE   = 2'b11
  } result_e;

  // A tie outranks a right verdict.
  function automatic result_e verdict(
    input logic right,
    input logic tie
  );
    if (tie) begin
      return RES_TIE;
    end else if (right) begin
      return RES_RIGHT;
    end
    return RES_LEFT;
  endfunction

endpackage

// File: rtl/speed_round_ctrl_if.sv
// Speed round bundle: game FSM controls, push-counter link and display.
// The sequencer takes the slave side; the game/test side takes master.
interface speed_round_ctrl_if;
  logic       start;
  logic       abort;
  logic       speed_right;
  logic       speed_tie;
  logic       speedRound;
  logic       speedExit;
  logic       busy;
  logic [3:0] time_left;
  logic       win_right;
  logic       win_left;
  logic       win_tie;
  logic [1:0] last_result;

  modport master (
    output start, abort, speed_right, speed_tie,
    input  speedRound, speedExit, busy, time_left,
    input  win_right, win_left, win_tie, last_result
  );

  modport slave (
    input  start, abort, speed_right, speed_tie,
    output speedRound, speedExit, busy, time_left,
    output win_right, win_left, win_tie, last_result
  );
endinterface

// File: rtl/speed_round_ctrl_sec_timer.sv
// Seconds timer: tick prescaler plus loadable 4-bit down-counter.
// Load restarts the prescaler so each phase gets whole seconds.
module sec_timer #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       tick,
  output logic       done,
  output logic [3:0] count
);

  localparam int PW = (TICK_CYCLES > 1) ?
                      $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    cnt_q, cnt_d;

  assign tick  = en && (pre_q == PMAX);
  // done flags the final second; the caller pairs it with tick
  assign done  = (cnt_q == 4'd1);
  assign count = cnt_q;

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load) begin
      pre_d = '0;
      cnt_d = load_val;
    end else if (en) begin
      if (tick) begin
        pre_d = '0;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/speed_round_ctrl.sv
// Speed round sequencer: arm countdown, count window, settle, verdict.
// All outputs are registered; the push counter sees a clean window.
module speed_round_ctrl
  import speed_round_ctrl_pkg::*;
#(
  parameter int TICK_CYCLES   = 50_000_000,
  parameter int ARM_SECS      = 3,
  parameter int ROUND_SECS    = 10,
  parameter int SETTLE_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  speed_round_ctrl_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SMAX = SW'(SETTLE_CYCLES - 1);

  state_e        state_q, state_d;
  result_e       res_q, res_d;
  result_e       last_q, last_d;
  logic          abort_q, abort_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          round_q, round_d;
  logic          exit_q, exit_d;
  logic          busy_q, busy_d;
  logic          wr_q, wr_d;
  logic          wl_q, wl_d;
  logic          wt_q, wt_d;

  logic       t_load, t_en, t_tick, t_done;
  logic [3:0] t_val, t_count;

  sec_timer #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .tick     (t_tick),
    .done     (t_done),
    .count    (t_count)
  );

  logic phase_end;
  assign phase_end = t_tick && t_done;

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    abort_d  = abort_q;
    settle_d = '0;
    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (bus.start && !bus.abort) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (bus.abort) begin
          state_d = S_EXIT;
          abort_d = 1'b1;
        end else if (phase_end) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (bus.abort) begin
          state_d = S_EXIT;
          abort_d = 1'b1;
        end else if (phase_end) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (bus.abort) begin
          state_d = S_EXIT;
          abort_d = 1'b1;
        end else if (settle_q == SMAX) begin
          state_d = S_DECIDE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_DECIDE: begin
        state_d = S_EXIT;
        if (bus.abort) begin
          abort_d = 1'b1;
        end else begin
          res_d = verdict(bus.speed_right, bus.speed_tie);
        end
      end
      S_EXIT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every state change reloads the timer, zeroing it outside ARM/ROUND.
  always_comb begin
    t_load = (state_d != state_q);
    t_en   = (state_q == S_ARM) || (state_q == S_ROUND);
    t_val  = 4'd0;
    if (state_d == S_ARM) begin
      t_val = 4'(ARM_SECS);
    end else if (state_d == S_ROUND) begin
      t_val = 4'(ROUND_SECS);
    end
  end

  logic decided;
  assign decided = (state_q == S_DECIDE) && !abort_d;

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && state_d == S_ARM) begin
      last_d = RES_NONE;
    end else if (state_q == S_EXIT && !abort_q) begin
      last_d = res_q;
    end
    round_d = (state_d == S_ROUND);
    exit_d  = (state_d == S_EXIT);
    busy_d  = (state_d != S_IDLE);
    wr_d    = decided && (res_d == RES_RIGHT);
    wl_d    = decided && (res_d == RES_LEFT);
    wt_d    = decided && (res_d == RES_TIE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      res_q    <= RES_NONE;
      last_q   <= RES_NONE;
      abort_q  <= 1'b0;
      settle_q <= '0;
      round_q  <= 1'b0;
      exit_q   <= 1'b0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      wl_q     <= 1'b0;
      wt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      last_q   <= last_d;
      abort_q  <= abort_d;
      settle_q <= settle_d;
      round_q  <= round_d;
      exit_q   <= exit_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      wl_q     <= wl_d;
      wt_q     <= wt_d;
    end
  end

  assign bus.speedRound  = round_q;
  assign bus.speedExit   = exit_q;
  assign bus.busy        = busy_q;
  assign bus.time_left   = t_count;
  assign bus.win_right   = wr_q;
  assign bus.win_left    = wl_q;
  assign bus.win_tie     = wt_q;
  assign bus.last_result = last_q;

endmodule

// File: tb/tb_speed_round_ctrl.sv
// Bench for speed_round_ctrl: per-cycle waveform checks plus a
// scoreboard of expected round outcomes popped on each speedExit.
module tb_speed_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  speed_round_ctrl_if bus ();

  speed_round_ctrl #(
    .TICK_CYCLES   (4),
    .ARM_SECS      (1),
    .ROUND_SECS    (3),
    .SETTLE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] win;
    logic [1:0] lr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] wins();
    return {bus.win_right, bus.win_left, bus.win_tie};
  endfunction

  // ab: abort driven in that cycle; rs1/rs2: stray starts;
  // ra: async reset asserted mid-cycle (round is then dropped).
  task automatic run_round(
    input bit r,
    input bit t,
    input int ab,
    input int rs1,
    input int rs2,
    input int ra
  );
    exp_t       e;
    exp_t       it;
    int         end_c;
    logic [1:0] lr_exp;
    logic [3:0] tl;
    end_c = (ab > 0) ? ab + 1 : 22;
    e.cyc = end_c;
    if (ab > 0) begin
      e.win = 3'b000; e.lr = 2'b00;
    end else if (t) begin
      e.win = 3'b001; e.lr = 2'b11;
    end else if (r) begin
      e.win = 3'b100; e.lr = 2'b10;
    end else begin
      e.win = 3'b010; e.lr = 2'b01;
    end
    if (ra == 0) sb.push_back(e);
    lr_exp = 2'b00;
    bus.speed_right = r;
    bus.speed_tie   = t;
    bus.abort       = 1'b0;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (c >= end_c)      tl = 4'd0;
      else if (c <= 4)     tl = 4'd1;
      else if (c <= 16)    tl = 4'(3 - (c - 5) / 4);
      else                 tl = 4'd0;
      chk("busy", 32'(bus.busy), 32'(c <= end_c));
      chk("round", 32'(bus.speedRound),
          32'(c >= 5 && c <= 16 && c < end_c));
      chk("exit", 32'(bus.speedExit), 32'(c == end_c));
      chk("time_left", 32'(bus.time_left), 32'(tl));
      if (bus.speedExit) begin
        chk("sb_avail", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          it = sb.pop_front();
          chk("exit_cyc", 32'(c), 32'(it.cyc));
          chk("win", 32'(wins()), 32'(it.win));
          lr_exp = it.lr;
        end
      end else begin
        chk("win_idle", 32'(wins()), 32'd0);
      end
      chk("last_result", 32'(bus.last_result),
          32'((c > end_c) ? lr_exp : 2'b00));
      if (c == ra) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_round", 32'(bus.speedRound), 32'd0);
        chk("rst_tl", 32'(bus.time_left), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        #1 rst = 1'b0;
        return;
      end
      bus.abort = (c == ab);
      bus.start = (c == rs1) || (c == rs2);
      @(posedge clk); #1;
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.speed_right = 1'b0;
    bus.speed_tie   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy0", 32'(bus.busy), 32'd0);
    chk("rst_round0", 32'(bus.speedRound), 32'd0);
    chk("rst_exit0", 32'(bus.speedExit), 32'd0);
    chk("rst_tl0", 32'(bus.time_left), 32'd0);
    chk("rst_win0", 32'(wins()), 32'd0);
    chk("rst_lr0", 32'(bus.last_result), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_round(1'b1, 1'b0, 0, 0, 0, 0);
    run_round(1'b1, 1'b1, 0, 0, 0, 0);
    run_round(1'b0, 1'b0, 0, 0, 0, 0);
    run_round(1'b1, 1'b0, 8, 0, 0, 0);
    run_round(1'b1, 1'b0, 0, 3, 10, 0);

    // start and abort together in IDLE: nothing happens
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sa_busy", 32'(bus.busy), 32'd0);
      chk("sa_exit", 32'(bus.speedExit), 32'd0);
      chk("sa_lr", 32'(bus.last_result), 32'd2);
      @(posedge clk); #1;
    end

    run_round(1'b1, 1'b0, 0, 0, 0, 8);
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_lr", 32'(bus.last_result), 32'd0);
    chk("post_rst_sb", 32'(sb.size()), 32'd0);
    run_round(1'b1, 1'b0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
